// File: rtl/avalon_st_pkg.sv
// Shared Avalon-ST definitions: default payload widths and the beat layout.
// Beat layout on the wire is {data, sop, eop, empty}, MSB first.
package avalon_st_pkg;

  localparam int unsigned ST_DATA_W    = 24;
  localparam int unsigned ST_EMPTY_W   = 2;
  localparam int unsigned ST_PAYLOAD_W = ST_DATA_W + 2 + ST_EMPTY_W;

  typedef struct packed {
    logic [ST_DATA_W-1:0]  data;
    logic                  sop;
    logic                  eop;
    logic [ST_EMPTY_W-1:0] empty;
  } st_beat_t;

endpackage

// File: rtl/st_sync_fifo.sv
// Small synchronous first-word-fall-through FIFO.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (clears pointers/count only)
//   wr_i, wr_data_i : push one entry
//   rd_i            : pop the head entry (caller guarantees count_o != 0)
//   rd_data_o       : head entry, combinational from storage
//   count_o         : current occupancy
//   count_next_c    : occupancy after this cycle's push/pop
module st_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 28
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [$clog2(DEPTH):0]     count_next_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_i);
    count_d  = count_q + CNT_W'(wr_i) - CNT_W'(rd_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; it is only ever read behind count.
  always_ff @(posedge clk) begin
    if (wr_i && !reset) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o    = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_c = count_d;

  overflow_a: assert property (@(posedge clk) disable iff (reset)
    !(wr_i && !rd_i && (count_q == CNT_W'(DEPTH))));

  underflow_a: assert property (@(posedge clk) disable iff (reset)
    !(rd_i && (count_q == '0)));

endmodule

// File: rtl/avalon_st_rl1_to_rl0_timing_adapter.sv
// Avalon-ST timing adapter: ready-latency-1 sink side to ready-latency-0 source side.
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   in_ready                     : registered sink ready (readyLatency 1)
//   in_valid/data/sop/eop/empty  : upstream beat, honoured one cycle after in_ready
//   out_ready                    : downstream ready (readyLatency 0)
//   out_valid/data/sop/eop/empty : buffered head beat, first-word fall-through
module avalon_st_rl1_to_rl0_timing_adapter
  import avalon_st_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DATA_W  = ST_DATA_W,
  parameter int unsigned EMPTY_W = ST_EMPTY_W
) (
  input  logic               clk,
  input  logic               reset,
  output logic               in_ready,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_startofpacket,
  input  logic               in_endofpacket,
  input  logic [EMPTY_W-1:0] in_empty,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty
);

  localparam int unsigned PAYLOAD_W = DATA_W + 2 + EMPTY_W;
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W     = CNT_W + 1;

  logic                 ready_d_q, ready_d_d;
  logic                 in_ready_q, in_ready_d;
  logic                 wr_c, rd_c;
  logic [CNT_W-1:0]     count, count_next;
  logic [PAYLOAD_W-1:0] wr_payload, rd_payload;

  // Handshake and credit: a beat may still land one cycle after in_ready,
  // so that outstanding credit is counted as if the slot were already used.
  always_comb begin
    wr_c       = in_valid && ready_d_q;
    rd_c       = out_valid && out_ready;
    wr_payload = {in_data, in_startofpacket, in_endofpacket, in_empty};
    ready_d_d  = in_ready_q;
    in_ready_d = ({1'b0, count_next} + SUM_W'(in_ready_q)) < SUM_W'(DEPTH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_d_q  <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      ready_d_q  <= ready_d_d;
      in_ready_q <= in_ready_d;
    end
  end

  st_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAYLOAD_W)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .wr_i         (wr_c),
    .wr_data_i    (wr_payload),
    .rd_i         (rd_c),
    .rd_data_o    (rd_payload),
    .count_o      (count),
    .count_next_c (count_next)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (count != '0);
  assign {out_data, out_startofpacket, out_endofpacket, out_empty} = rd_payload;

endmodule

// File: doc/avalon_st_rl1_to_rl0_timing_adapter.md
# avalon_st_rl1_to_rl0_timing_adapter

Avalon-ST timing adapter that takes a ready-latency-1 source and presents a ready-latency-0 source to a downstream sink. It is the counterpart of our latency-0-to-1 timing adapters in the QSYS video/capture paths. A beat may already be in flight when `in_ready` drops, so the block must buffer. It carries the standard 24-bit data, SOP, EOP and 2-bit empty payload unchanged through a small synchronous FIFO.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries. Must be a power of two and ≥2. Full throughput requires ≥4.
- `DATA_W`, 24: data width.
- `EMPTY_W`, 2: empty width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_ready`  out  1  sink ready; readyLatency = 1.
- `in_valid`  in  1  beat valid. Honoured only one cycle after `in_ready` was high.
- `in_data`  in  DATA_W
- `in_startofpacket`  in  1
- `in_endofpacket`  in  1
- `in_empty`  in  EMPTY_W
- `out_ready`  in  1  downstream ready; readyLatency = 0.
- `out_valid`  out  1
- `out_data`  out  DATA_W
- `out_startofpacket`  out  1
- `out_endofpacket`  out  1
- `out_empty`  out  EMPTY_W

## Operation
- Payload packing: `{data, sop, eop, empty}`, width PAYLOAD_W = DATA_W+2+EMPTY_W (28 by default). Unpacked identically on output. No field is modified.
- `ready_d` register: `in_ready` delayed one cycle.
  - Write (`wr`) = `in_valid && ready_d`.
  - `in_valid` while `ready_d`=0 is ignored and the data is dropped. This is a protocol violation by upstream, not an adapter error.
- Read (`rd`) = `out_valid && out_ready`.
- `out_valid` = (`count` != 0). Output payload = storage[`rd_ptr`], which is first-word fall-through and combinational from registers.
- State registers:
  - `wr_ptr`, `rd_ptr`: log2(DEPTH) bits each, natural wrap at DEPTH.
  - `count`: log2(DEPTH)+1 bits.
  - `count_next` = `count` + `wr` − `rd`.
- Simultaneous `wr` and `rd`: `count` is unchanged and both pointers advance. This includes `count`=DEPTH−1 and `count`=1.
- Credit rule: `in_ready` is a register with `in_ready` ← (`count_next` + `in_ready`) < DEPTH.
  - This guarantees that a beat arriving one cycle after any `in_ready`=1 always finds space.
  - Overflow (`wr` while `count`=DEPTH and no `rd`) is unreachable. Verification asserts it never occurs.
- Underflow is impossible because `rd` requires `out_valid`.
- Packet boundaries have no special handling. Back-to-back packets and single-beat packets (SOP and EOP in the same beat) pass through as-is.

## Timing
- Reset values: `in_ready`=0, `ready_d`=0, `count`=0, `wr_ptr`=`rd_ptr`=0, `out_valid`=0. Storage contents are not reset.
- First cycle after `reset` falls: `in_ready` rises at the following clock edge. The first beat is accepted the cycle after that.
- Latency: a beat written at edge t is visible on `out_*` with `out_valid`=1 in cycle t+1.
- Throughput: with DEPTH≥4 and `out_ready` held at 1, `in_ready` stays at 1 and the block sustains 1 beat per clock.
- Backpressure: `out_ready` falling at cycle t causes `in_ready` to fall when the credit rule trips. At most one further beat is accepted after `in_ready` falls.
- Reset mid-operation: `reset` asserted in any cycle clears the FIFO at that edge. Buffered beats are discarded, even mid-packet. No writes or reads take effect in a reset cycle.
- `out_*` payload must be stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Shared package `avalon_st_pkg` holds:
  - constants `ST_DATA_W`=24, `ST_EMPTY_W`=2, `ST_PAYLOAD_W`=28;
  - packed struct typedef `st_beat_t` {data, sop, eop, empty}.
- One sub-module, `st_sync_fifo` (parameters DEPTH and WIDTH, FWFT, with a `count` output). The top level holds `ready_d`, the credit logic and payload pack/unpack.

## Test plan
- Reset, then a stream of 8 beats (data 0x000001..0x000008) with `out_ready`=1 → `in_ready`=1 from the second post-reset edge. Outputs match 1:1, one cycle later, with no gaps.
- `out_ready`=0 for 10 cycles during a continuous stream → exactly DEPTH beats are buffered, `count` never exceeds DEPTH, and no beat is lost. On release, the data drains in order.
- Single-beat packet (SOP=1, EOP=1, empty=2, data 0xABCDEF) → identical fields appear on the output.
- `in_valid`=1 asserted while `ready_d`=0 → no write occurs, `count` is unchanged, and that beat never appears on the output.
- `out_ready` toggled every cycle with random `in_valid` for 10k beats → scoreboard ordering matches and the overflow assertion never fires.
- `reset` pulsed with 3 beats buffered → `out_valid`=0 and `in_ready`=0 on the next cycle. The stream resumes cleanly afterwards.
